// File: rtl/switch_input_conditioner.sv
// Synchronises and debounces two slide switches and a push button, and queues the
// debounced switch value on each button press in a small first-word-fall-through FIFO.
module switch_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [1:0]                    sw_in,
   input  logic                          btn_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [1:0]                    out_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int COUNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(FIFO_DEPTH);

   // Bit 2 carries the button, bits 1:0 the switches.
   logic [2:0] syncA;
   logic [2:0] syncB;
   logic [2:0] stableBits;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syncA <= '0;
         syncB <= '0;
      end else begin
         syncA <= {btn_in, sw_in};
         syncB <= syncA;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : gDebounce
         logic             stable;
         logic [CNT_W-1:0] cnt;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               stable <= 1'b0;
               cnt    <= '0;
            end else if (syncB[gi] == stable) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               stable <= syncB[gi];
               cnt    <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end

         assign stableBits[gi] = stable;
      end
   endgenerate

   logic btnPrev;
   logic press;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) btnPrev <= 1'b0;
      else     btnPrev <= stableBits[2];
   end

   assign press = stableBits[2] & ~btnPrev;

   logic [1:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wrPtr;
   logic [PTR_W-1:0]   rdPtr;
   logic [COUNT_W-1:0] count;
   logic               full;
   logic               pop;
   logic               push;

   assign full     = (count == COUNT_MAX);
   assign pop      = out_valid & out_ready;
   // A pop on the same cycle frees the slot, so a full FIFO can still take the press.
   assign push     = press & (~full | pop);
   assign overflow = press & full & ~pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wrPtr] <= stableBits[1:0];
            wrPtr      <= wrPtr + PTR_W'(1);
         end
         if (pop) rdPtr <= rdPtr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + COUNT_W'(1);
            2'b01:   count <= count - COUNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign out_valid  = (count != '0);
   assign out_data   = mem[rdPtr];
   assign fifo_count = count;

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Scoreboard bench for switch_input_conditioner with short debounce and a 4-entry FIFO.
module tb_switch_input_conditioner;

   localparam int DC = 4;
   localparam int FD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] sw_in = 2'b00;
   logic       btn_in = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [1:0] out_data;
   logic [2:0] fifo_count;
   logic       overflow;

   int         checkCount = 0;
   int         failCount  = 0;
   int         overflowSeen = 0;
   logic [1:0] expQ [$];

   switch_input_conditioner #(.DEBOUNCE_CYCLES(DC), .FIFO_DEPTH(FD)) dut (
      .clk       (clk),
      .rst       (rst),
      .sw_in     (sw_in),
      .btn_in    (btn_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .fifo_count(fifo_count),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
      end else begin
         $display("ok   %s: %0d", tag, observed);
      end
   endtask

   // Sample just after the negedge (inputs already set for the next posedge), then advance.
   task automatic cycle();
      logic [1:0] exp;
      #1;
      if (overflow) overflowSeen++;
      if (out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checkValue("sb_underflow", expQ.size(), 1);
         end else begin
            exp = expQ.pop_front();
            checkValue("pop_data", out_data, exp);
         end
      end
      @(negedge clk);
   endtask

   task automatic pressBtn(input logic [1:0] val, input bit expectPush);
      sw_in = val;
      repeat (8) cycle();
      if (expectPush) expQ.push_back(val);
      btn_in = 1'b1;
      repeat (8) cycle();
      btn_in = 1'b0;
      repeat (8) cycle();
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 20 && expQ.size() != 0; i++) cycle();
      out_ready = 1'b0;
      checkValue("drain_sb_empty", expQ.size(), 0);
      cycle();
      checkValue("drain_count", fifo_count, 0);
   endtask

   initial begin
      logic [1:0] held;
      logic [2:0] cntBefore;
      int         ovBefore;

      #2;
      checkValue("rst_valid", out_valid, 0);
      checkValue("rst_count", fifo_count, 0);
      checkValue("rst_overflow", overflow, 0);
      checkValue("rst_data", out_data, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Basic press with latency check
      sw_in = 2'b10;
      repeat (8) cycle();
      expQ.push_back(2'b10);
      btn_in = 1'b1;
      repeat (6) cycle();
      checkValue("basic_not_yet", out_valid, 0);
      cycle();
      checkValue("basic_valid", out_valid, 1);
      checkValue("basic_data", out_data, 2'b10);
      checkValue("basic_count", fifo_count, 1);
      btn_in = 1'b0;
      repeat (10) cycle();
      checkValue("basic_release_count", fifo_count, 1);
      checkValue("basic_release_data", out_data, 2'b10);
      drain();

      // Glitch rejection: 3-cycle pulse dropped, 4-cycle pulse accepted
      btn_in = 1'b1;
      repeat (3) cycle();
      btn_in = 1'b0;
      repeat (10) cycle();
      checkValue("glitch3_count", fifo_count, 0);
      expQ.push_back(sw_in);
      btn_in = 1'b1;
      repeat (4) cycle();
      btn_in = 1'b0;
      repeat (10) cycle();
      checkValue("pulse4_count", fifo_count, 1);
      drain();

      // Overflow on the fifth press
      ovBefore = overflowSeen;
      pressBtn(2'd0, 1'b1);
      pressBtn(2'd1, 1'b1);
      pressBtn(2'd2, 1'b1);
      pressBtn(2'd3, 1'b1);
      checkValue("ovf_none_yet", overflowSeen - ovBefore, 0);
      pressBtn(2'd0, 1'b0);
      checkValue("ovf_count", fifo_count, 4);
      checkValue("ovf_pulses", overflowSeen - ovBefore, 1);
      drain();

      // Full FIFO, push and pop on the press cycle
      pressBtn(2'd3, 1'b1);
      pressBtn(2'd2, 1'b1);
      pressBtn(2'd1, 1'b1);
      pressBtn(2'd0, 1'b1);
      checkValue("full_count", fifo_count, 4);
      ovBefore = overflowSeen;
      sw_in = 2'd1;
      repeat (8) cycle();
      expQ.push_back(2'd1);
      btn_in = 1'b1;
      repeat (6) cycle();
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      checkValue("fullpp_count", fifo_count, 4);
      checkValue("fullpp_overflow", overflowSeen - ovBefore, 0);
      btn_in = 1'b0;
      repeat (10) cycle();

      // Backpressure: head holds, then exactly one pop
      held = expQ[0];
      for (int i = 0; i < 10; i++) begin
         cycle();
         checkValue("bp_hold", out_data, held);
      end
      cntBefore = fifo_count;
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      checkValue("bp_one_pop", fifo_count, cntBefore - 3'd1);
      checkValue("bp_new_head", out_data, expQ[0]);
      drain();

      // Asynchronous reset mid-cycle with two entries queued
      pressBtn(2'd2, 1'b1);
      pressBtn(2'd1, 1'b1);
      checkValue("prerst_count", fifo_count, 2);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkValue("arst_valid", out_valid, 0);
      checkValue("arst_count", fifo_count, 0);
      checkValue("arst_overflow", overflow, 0);
      checkValue("arst_data", out_data, 0);
      expQ.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (4) cycle();
      checkValue("postrst_count", fifo_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
